// File: rtl/jk_btn_cmd.sv
// jk_btn_cmd: synchronise and debounce two buttons into one-cycle j/k commands with a command counter.
// Define AUTOREPEAT_EN to re-fire a held button's press event every REPEAT_CYCLES cycles.
module jk_btn_cmd #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_set,
  input  logic       btn_clr,
  output logic       j,
  output logic       k,
  output logic       set_level,
  output logic       clr_level,
  output logic [7:0] cmd_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;
  logic [1:0] raw, press, lvl_nx;
  assign raw = {btn_clr, btn_set};
  for (genvar g = 0; g < 2; g++) begin : ch
    logic [1:0] sync;
    logic s, fire;
    state_t st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    assign s = sync[1];
    always_ff @(posedge clk) begin
      sync <= rst_n ? {sync[0], raw[g]} : 2'b0;
      st <= rst_n ? st_nx : RELEASED;
      cnt <= rst_n ? cnt_nx : '0;
    end
    always_comb begin
      st_nx = st;
      cnt_nx = cnt;
      fire = 1'b0;
      case (st)
        RELEASED: if (s) begin
          st_nx = (DMAX == CW'(1)) ? PRESSED : PRESS_PEND;
          cnt_nx = CW'(1);
          fire = (DMAX == CW'(1));
        end
        PRESS_PEND: if (!s) st_nx = RELEASED;
        else begin
          cnt_nx = cnt + CW'(1);
          if (cnt_nx == DMAX) begin
            st_nx = PRESSED;
            fire = 1'b1;
          end
        end
        PRESSED: if (!s) begin
          st_nx = (DMAX == CW'(1)) ? RELEASED : RELEASE_PEND;
          cnt_nx = CW'(1);
        end
        default: if (s) st_nx = PRESSED;
        else begin
          cnt_nx = cnt + CW'(1);
          if (cnt_nx == DMAX) st_nx = RELEASED;
        end
      endcase
    end
    assign lvl_nx[g] = (st_nx == PRESSED) || (st_nx == RELEASE_PEND);
`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt;
    logic rfire;
    // Interval restarts whenever PRESSED is (re)entered or left, and after each repeat.
    assign rfire = (st == PRESSED) && (st_nx == PRESSED) && (rpt == RMAX);
    always_ff @(posedge clk)
      rpt <= (!rst_n || rfire || st != PRESSED || st_nx != PRESSED) ? '0 : rpt + RW'(1);
    assign press[g] = fire | rfire;
`else
    assign press[g] = fire;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      j <= 1'b0;
      k <= 1'b0;
      set_level <= 1'b0;
      clr_level <= 1'b0;
      cmd_count <= '0;
    end else begin
      j <= press[0];
      k <= press[1];
      set_level <= lvl_nx[0];
      clr_level <= lvl_nx[1];
      cmd_count <= cmd_count + 8'(j | k);
    end
  end
endmodule

// File: tb/tb_jk_btn_cmd.sv
// tb_jk_btn_cmd: scoreboard bench; a run-length debounce model predicts pulses, levels and command count.
module tb_jk_btn_cmd;
  localparam int D = 4;
  localparam int R = 8;
  logic clk = 0, rst_n = 0, btn_set = 0, btn_clr = 0;
  logic j, k, set_level, clr_level;
  logic [7:0] cmd_count;
  jk_btn_cmd #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_clr(btn_clr),
    .j(j), .k(k), .set_level(set_level), .clr_level(clr_level), .cmd_count(cmd_count)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic j; logic k;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [1:0] ms1, ms2, mlvl;
  int run [2];
`ifdef AUTOREPEAT_EN
  int since [2];
`endif
  logic prev_fire;
  logic [7:0] exp_count;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // Reference: a level flips after D consecutive synchronised samples that disagree with it.
  always @(posedge clk) begin
    logic [1:0] raw, f;
    logic sv;
    cyc++;
    raw = {btn_clr, btn_set};
    if (!rst_n) begin
      ms1 = 0; ms2 = 0; mlvl = 0; prev_fire = 0; exp_count = 0;
      for (int c = 0; c < 2; c++) begin
        run[c] = 0;
`ifdef AUTOREPEAT_EN
        since[c] = 0;
`endif
      end
    end else begin
      exp_count = exp_count + 8'(prev_fire);
      f = 0;
      for (int c = 0; c < 2; c++) begin
        sv = ms2[c];
        ms2[c] = ms1[c];
        ms1[c] = raw[c];
        if (sv != mlvl[c]) begin
          run[c]++;
`ifdef AUTOREPEAT_EN
          since[c] = 0;
`endif
          if (run[c] == D) begin
            mlvl[c] = sv;
            run[c] = 0;
            f[c] = sv;
          end
        end else begin
`ifdef AUTOREPEAT_EN
          since[c] = (mlvl[c] && run[c] == 0) ? since[c] + 1 : 0;
          if (since[c] == R) begin
            f[c] = 1;
            since[c] = 0;
          end
`endif
          run[c] = 0;
        end
      end
      if (|f) q.push_back('{cyc, f[0], f[1]});
      prev_fire = |f;
    end
  end
  always @(negedge clk) begin
    if (j | k) begin
      if (q.size() == 0) chk("spurious_pulse", {30'd0, k, j}, 0);
      else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_jk", {30'd0, k, j}, {30'd0, e.k, e.j});
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      chk("missed_pulse", {30'd0, k, j}, {30'd0, q[0].k, q[0].j});
      void'(q.pop_front());
    end
    chk("set_level", set_level, mlvl[0]);
    chk("clr_level", clr_level, mlvl[1]);
    chk("cmd_count", cmd_count, exp_count);
  end
  task automatic cyc_wait(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(logic s, logic c, int n);
    btn_set = s;
    btn_clr = c;
    cyc_wait(n);
  endtask
  initial begin
    rst_n = 0;
    btn_set = 1;
    btn_clr = 1;
    cyc_wait(3);
    rst_n = 1;
    cyc_wait(12);
    drive(0, 0, 12);
    drive(1, 0, 20); drive(0, 0, 12);
    drive(0, 1, 3); drive(0, 0, 12);
    drive(1, 1, 10); drive(0, 0, 12);
    drive(1, 0, 10); drive(0, 0, 2); drive(1, 0, 1); drive(0, 0, 10);
    repeat (256) begin
      drive(1, 0, 7);
      drive(0, 0, 7);
    end
    drive(1, 0, 30); drive(0, 0, 12);
    drive(0, 1, 30); drive(1, 1, 30); drive(0, 0, 12);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        rst_n = 0;
        cyc_wait(2);
        rst_n = 1;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 2 * D + 3));
    end
    drive(0, 0, 20);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
